// File: rtl/ex_mem_resolver.sv
// EX/MEM resolver: decodes executed instructions, turns taken branches into redirects and
// signed overflow into a trap, and queues writeback/memory work in a small output FIFO.
module ex_mem_resolver #(
  parameter int DEPTH        = 2,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_result,
  input  logic [2:0]  in_flags,
  input  logic [31:0] in_store_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_wb_en,
  output logic [4:0]  out_wb_addr,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic [31:0] out_store_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        exc_valid,
  output logic [31:0] exc_pc,
  input  logic        exc_ack
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] result;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_data;
  } entry_t;

  typedef enum logic {RUN, TRAP} state_e;

  state_e       state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]   squash_cnt_q, squash_cnt_d;
  logic         redirect_valid_q, redirect_valid_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic         exc_valid_q, exc_valid_d;
  logic [31:0]  exc_pc_q, exc_pc_d;
  entry_t       mem_q [DEPTH];
  entry_t       mem_d [DEPTH];

  // ---------------- decode ----------------
  logic [5:0] op, fn;
  logic [4:0] dest;
  logic       dec_push, dec_br, dec_ovf, is_wb;
  entry_t     dec_ent;

  assign op = in_instr[31:26];
  assign fn = in_instr[5:0];

  always_comb begin
    dec_push = 1'b0;
    dec_br   = 1'b0;
    dec_ovf  = 1'b0;
    is_wb    = 1'b0;
    dest     = in_instr[20:16];
    dec_ent  = '0;
    dec_ent.result     = in_result;
    dec_ent.store_data = in_store_data;
    case (op)
      6'h00: begin
        dest = in_instr[15:11];
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: begin
            dec_push = 1'b1;
            is_wb    = 1'b1;
            dec_ovf  = (fn == 6'h20 || fn == 6'h22) && in_flags[2];
          end
          default: ;
        endcase
      end
      6'h08: begin
        dec_push = 1'b1;
        is_wb    = 1'b1;
        dec_ovf  = in_flags[2];
      end
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
        dec_push = 1'b1;
        is_wb    = 1'b1;
      end
      6'h23: begin
        dec_push       = 1'b1;
        is_wb          = 1'b1;
        dec_ent.mem_rd = 1'b1;
      end
      6'h2b: begin
        dec_push       = 1'b1;
        dec_ent.mem_wr = 1'b1;
      end
      6'h04, 6'h05: dec_br = 1'b1;
      default: ;
    endcase
    dec_ent.wb_en   = is_wb && (dest != 5'd0);
    dec_ent.wb_addr = dec_ent.wb_en ? dest : 5'd0;
  end

  // ---------------- control ----------------
  logic acc, pop, live, do_push, taken;
  logic [31:0] br_target;

  assign in_ready  = rst_n && (state_q == RUN) && (count_q < CW'(DEPTH));
  assign acc       = in_valid && in_ready;
  assign pop       = (count_q != '0) && out_ready;
  assign live      = acc && (squash_cnt_q == 3'd0);
  assign taken     = live && dec_br && !in_flags[0];
  assign do_push   = live && dec_push && !dec_ovf;
  assign br_target = in_pc + 32'd4 + {{14{in_result[15]}}, in_result[15:0], 2'b00};

  always_comb begin
    state_d          = state_q;
    exc_valid_d      = exc_valid_q;
    exc_pc_d         = exc_pc_q;
    squash_cnt_d     = squash_cnt_q;
    redirect_valid_d = taken;
    redirect_pc_d    = taken ? br_target : redirect_pc_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    mem_d            = mem_q;

    // Squashed entries still count as accepted, so the counter ticks before any decode action.
    if (acc && squash_cnt_q != 3'd0)
      squash_cnt_d = squash_cnt_q - 3'd1;
    else if (taken)
      squash_cnt_d = 3'(SQUASH_DEPTH);

    if (state_q == RUN) begin
      if (live && dec_ovf) begin
        state_d     = TRAP;
        exc_valid_d = 1'b1;
        exc_pc_d    = in_pc;
      end
    end else if (exc_ack) begin
      state_d     = RUN;
      exc_valid_d = 1'b0;
    end

    if (do_push) begin
      mem_d[wr_ptr_q] = dec_ent;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !pop)      count_d = count_q + CW'(1);
    else if (!do_push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= RUN;
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      squash_cnt_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      exc_valid_q      <= 1'b0;
      exc_pc_q         <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      squash_cnt_q     <= squash_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      exc_valid_q      <= exc_valid_d;
      exc_pc_q         <= exc_pc_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) mem_q <= mem_d;

  entry_t head;
  assign head           = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign out_valid      = (count_q != '0);
  assign out_result     = head.result;
  assign out_wb_en      = head.wb_en;
  assign out_wb_addr    = head.wb_addr;
  assign out_mem_rd     = head.mem_rd;
  assign out_mem_wr     = head.mem_wr;
  assign out_store_data = head.store_data;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign exc_valid      = exc_valid_q;
  assign exc_pc         = exc_pc_q;

  logic unused_bits;
  assign unused_bits = ^{in_instr[25:21], in_instr[10:6], in_flags[1]};
endmodule
